// File: rtl/data_mem_ctrl.sv
// Load/store sequencer between the core memory stage and a word-wide data memory.
// Sub-word stores use read-modify-write because the memory has only a whole-word write enable.
module data_mem_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            reqValid,
  output logic            reqReady,
  input  logic            reqWrite,
  input  logic [1:0]      reqSize,
  input  logic            reqUnsigned,
  input  logic [XLEN-1:0] reqAddr,
  input  logic [XLEN-1:0] reqWdata,
  output logic            rspValid,
  output logic [XLEN-1:0] rspData,
  output logic            rspError,
  output logic [XLEN-1:0] memAddress,
  output logic [XLEN-1:0] memWriteData,
  output logic            memWriteEnable,
  output logic            memReadEnable,
  input  logic [XLEN-1:0] memReadData
);
  // state    | meaning
  // IDLE     | ready for a request
  // RD       | load: read strobe
  // RD_WAIT  | load: extract and extend read data
  // RMW_RD   | sub-word store: read strobe
  // RMW_WAIT | sub-word store: merge new lanes into read word
  // WR       | write strobe
  // DONE     | one-cycle response
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD       = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] RMW_RD   = 3'd3;
  localparam logic [2:0] RMW_WAIT = 3'd4;
  localparam logic [2:0] WR       = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  logic [2:0]      state;
  logic [XLEN-1:0] addrQ;
  logic [XLEN-1:0] wdataQ;
  logic [XLEN-1:0] wordQ;
  logic [XLEN-1:0] rspDataQ;
  logic [1:0]      sizeQ;
  logic            unsignedQ;
  logic            rspErrorQ;

  logic            reqErr;
  logic [4:0]      shamt;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] loadData;
  logic [XLEN-1:0] laneMask;
  logic [XLEN-1:0] merged;

  always_comb begin
    reqErr = (reqSize == 2'b11) ||
             (reqSize == 2'b01 && reqAddr[0]) ||
             (reqSize == 2'b10 && reqAddr[1:0] != 2'b00);
  end

  // Alignment is already guaranteed, so a byte-granular shift also selects the right half lane.
  always_comb begin
    shamt    = {addrQ[1:0], 3'b000};
    shifted  = memReadData >> shamt;
    loadData = memReadData;
    case (sizeQ)
      2'b00: loadData = unsignedQ ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                  : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'b01: loadData = unsignedQ ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                  : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      default: loadData = memReadData;
    endcase
    laneMask = (sizeQ == 2'b00) ? (XLEN'(8'hFF) << shamt) : (XLEN'(16'hFFFF) << shamt);
    merged   = (memReadData & ~laneMask) | ((wdataQ << shamt) & laneMask);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      addrQ     <= '0;
      wdataQ    <= '0;
      wordQ     <= '0;
      sizeQ     <= '0;
      unsignedQ <= 1'b0;
      rspDataQ  <= '0;
      rspErrorQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            addrQ     <= reqAddr;
            sizeQ     <= reqSize;
            unsignedQ <= reqUnsigned;
            wdataQ    <= reqWdata;
            if (reqErr) begin
              rspDataQ  <= '0;
              rspErrorQ <= 1'b1;
              state     <= DONE;
            end else if (reqWrite && reqSize == 2'b10) begin
              wordQ <= reqWdata;
              state <= WR;
            end else if (reqWrite) begin
              state <= RMW_RD;
            end else begin
              state <= RD;
            end
          end
        end
        RD:       state <= RD_WAIT;
        RD_WAIT: begin
          rspDataQ  <= loadData;
          rspErrorQ <= 1'b0;
          state     <= DONE;
        end
        RMW_RD:   state <= RMW_WAIT;
        RMW_WAIT: begin
          wordQ <= merged;
          state <= WR;
        end
        WR: begin
          rspDataQ  <= '0;
          rspErrorQ <= 1'b0;
          state     <= DONE;
        end
        default:  state <= IDLE;
      endcase
    end
  end

  assign reqReady       = (state == IDLE);
  assign rspValid       = (state == DONE);
  assign rspData        = rspDataQ;
  assign rspError       = rspErrorQ;
  assign memReadEnable  = (state == RD) || (state == RMW_RD);
  assign memWriteEnable = (state == WR);
  assign memWriteData   = wordQ;
  assign memAddress     = (state == IDLE) ? '0 : {addrQ[XLEN-1:2], 2'b00};

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus random requests
// compared against a byte-addressed reference memory.
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid, reqReady, reqWrite, reqUnsigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata;
  logic        rspValid, rspError;
  logic [31:0] rspData;
  logic [31:0] memAddress, memWriteData, memReadData;
  logic        memWriteEnable, memReadEnable;

  int errors = 0;
  int checks = 0;

  logic [7:0]  refMem [0:63];
  logic [31:0] envMem [0:15];
  logic        preload;

  int          expLat, expRd, expWr;
  logic [31:0] expData, expWord, expAddr;
  logic        expErr;

  data_mem_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rstN(rstN),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddr(reqAddr), .reqWdata(reqWdata),
    .rspValid(rspValid), .rspData(rspData), .rspError(rspError),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memWriteEnable(memWriteEnable), .memReadEnable(memReadEnable),
    .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  // Word memory seen by the DUT; read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++)
        envMem[i] <= {refMem[4*i+3], refMem[4*i+2], refMem[4*i+1], refMem[4*i]};
    end else if (memWriteEnable) begin
      envMem[memAddress[5:2]] <= memWriteData;
    end
    if (memReadEnable) memReadData <= envMem[memAddress[5:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, ".reqReady"}, {31'b0, reqReady}, 32'd1);
    check({tag, ".rspValid"}, {31'b0, rspValid}, 32'd0);
    check({tag, ".rspData"}, rspData, 32'd0);
    check({tag, ".rspError"}, {31'b0, rspError}, 32'd0);
    check({tag, ".memWe"}, {31'b0, memWriteEnable}, 32'd0);
    check({tag, ".memRe"}, {31'b0, memReadEnable}, 32'd0);
  endtask

  // Reference behaviour: byte-addressed memory, plain arithmetic extension.
  task automatic modelReq(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input bit commit);
    int n;
    int base;
    logic [31:0] v;
    logic err;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(a[5:0]);
    expAddr = {a[31:2], 2'b00};
    expErr = err;
    expData = 32'd0;
    expRd = 0;
    expWr = 0;
    expWord = 32'd0;
    if (err) begin
      expLat = 1;
    end else if (!wr) begin
      expLat = 3;
      expRd = 1;
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(refMem[base+i]) << (8*i));
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      expData = v;
    end else begin
      expLat = (sz == 2'd2) ? 2 : 4;
      expRd = (sz == 2'd2) ? 0 : 1;
      expWr = 1;
      if (commit)
        for (int i = 0; i < n; i++) refMem[base+i] = 8'(wd >> (8*i));
      base = int'(expAddr[5:0]);
      expWord = {refMem[base+3], refMem[base+2], refMem[base+1], refMem[base]};
    end
  endtask

  task automatic startReq(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input bit commit);
    int w = 0;
    while (!reqReady && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("readyBeforeReq", {31'b0, reqReady}, 32'd1);
    modelReq(wr, sz, uns, a, wd, commit);
    reqValid = 1'b1;
    reqWrite = wr;
    reqSize = sz;
    reqUnsigned = uns;
    reqAddr = a;
    reqWdata = wd;
    @(posedge clk);
    #1 reqValid = 1'b0;
  endtask

  task automatic finishReq(input string tag);
    int lat = 0;
    int rd = 0;
    int wrc = 0;
    bit readyLow = 1'b1;
    logic [31:0] d = 32'd0;
    logic e = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (reqReady) readyLow = 1'b0;
      if (memReadEnable) begin
        rd++;
        check({tag, ".rdAddr"}, memAddress, expAddr);
      end
      if (memWriteEnable) begin
        wrc++;
        check({tag, ".wrAddr"}, memAddress, expAddr);
        check({tag, ".wrData"}, memWriteData, expWord);
      end
      if (rspValid) begin
        lat = k;
        d = rspData;
        e = rspError;
        break;
      end
    end
    check({tag, ".latency"}, 32'(lat), 32'(expLat));
    check({tag, ".rspData"}, d, expData);
    check({tag, ".rspError"}, {31'b0, e}, {31'b0, expErr});
    check({tag, ".readStrobes"}, 32'(rd), 32'(expRd));
    check({tag, ".writeStrobes"}, 32'(wrc), 32'(expWr));
    check({tag, ".readyLowWhileBusy"}, {31'b0, readyLow}, 32'd1);
    @(negedge clk);
    check({tag, ".pulseOneCycle"}, {31'b0, rspValid}, 32'd0);
    check({tag, ".readyAfter"}, {31'b0, reqReady}, 32'd1);
    check({tag, ".rspHeld"}, rspData, expData);
  endtask

  task automatic doReq(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    startReq(wr, sz, uns, a, wd, 1'b1);
    finishReq(tag);
  endtask

  initial begin
    logic        wr, uns;
    logic [1:0]  sz;
    logic [31:0] a, wd;

    rstN = 1'b0;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqSize = 2'd0;
    reqUnsigned = 1'b0;
    reqAddr = 32'd0;
    reqWdata = 32'd0;
    preload = 1'b0;
    for (int i = 0; i < 64; i++) refMem[i] = 8'($urandom);
    refMem[32'h20] = 8'h44;
    refMem[32'h21] = 8'h33;
    refMem[32'h22] = 8'h22;
    refMem[32'h23] = 8'h11;

    #12;
    checkIdleOutputs("reset");
    @(negedge clk) preload = 1'b1;
    @(negedge clk) preload = 1'b0;
    rstN = 1'b1;
    @(negedge clk);

    doReq("storeWord10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    doReq("loadWord10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    doReq("storeByte21", 1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA);
    check("rmwWordModel", expWord, 32'h1122AA44);
    doReq("loadSByte21", 1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
    check("loadSByteModel", expData, 32'hFFFFFFAA);
    doReq("loadUHalf22", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    check("loadUHalfModel", expData, 32'h00001122);
    doReq("misHalf03", 1'b0, 2'd1, 1'b0, 32'h03, 32'h0);
    doReq("misWord06", 1'b1, 2'd2, 1'b0, 32'h06, 32'h12345678);
    doReq("resSize", 1'b0, 2'd3, 1'b0, 32'h08, 32'h0);

    // Second request held valid while the first load is busy.
    startReq(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqSize = 2'd2;
    reqAddr = 32'h30;
    reqWdata = 32'hCAFEF00D;
    finishReq("busyLoad");
    startReq(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 1'b1);
    finishReq("heldStore");

    // Reset during RMW_WAIT of a byte store.
    startReq(1'b1, 2'd0, 1'b0, 32'h25, 32'h0000005A, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rmwAbort.busy", {31'b0, reqReady}, 32'd0);
    #2 rstN = 1'b0;
    #1 checkIdleOutputs("rmwAbort");
    @(negedge clk) rstN = 1'b1;
    doReq("afterRmwAbort", 1'b0, 2'd2, 1'b0, 32'h24, 32'h0);

    // Reset while the write strobe is high.
    startReq(1'b1, 2'd2, 1'b0, 32'h28, 32'h12345678, 1'b0);
    @(negedge clk);
    check("wrAbort.strobeHigh", {31'b0, memWriteEnable}, 32'd1);
    #2 rstN = 1'b0;
    #1 checkIdleOutputs("wrAbort");
    @(negedge clk) rstN = 1'b1;
    doReq("afterWrAbort", 1'b0, 2'd2, 1'b0, 32'h28, 32'h0);

    for (int t = 0; t < 150; t++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 63));
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      doReq("random", wr, sz, uns, a, wd);
    end

    for (int i = 0; i < 16; i++)
      check("finalMem", envMem[i], {refMem[4*i+3], refMem[4*i+2], refMem[4*i+1], refMem[4*i]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
